console_cmd_scheduler: RTL and testbench
========================================

# console_cmd_scheduler

Sequences edit commands into the console's single-command editing interface (insert / delete / move-cursor pulses with the `available` handshake). Two requesters share it: the keypad editor and the interpreter's program-output path. Requests are round-robin arbitrated into a small FIFO and issued to the console one at a time. The block sits between the requesters and the console module and drives its `please_wait` input.

## Interface

- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `SYM_W`, 4: symbol width, matching `symbol_to_insert`.
- `ACK_TIMEOUT`, 8: cycles to wait for `available` to fall after a pulse; ≥1.

Ports:

- `working_clock`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `kb_valid`  in  1  keypad request valid.
- `kb_op`  in  2  00 insert, 01 delete, 10 move left, 11 move right.
- `kb_symbol`  in  SYM_W  symbol for insert; ignored otherwise.
- `kb_ready`  out  1  keypad request accepted when `kb_valid & kb_ready`.
- `it_valid`, `it_op`, `it_symbol`, `it_ready`: interpreter requester, same widths and encoding.
- `symbol_to_insert`  out  SYM_W  symbol of the last issued command; held between commands.
- `insert`  out  1  one-cycle pulse.
- `delete`  out  1  one-cycle pulse.
- `move_cursor`  out  1  one-cycle pulse.
- `cursor_dir`  out  1  1 = right, 0 = left; held between commands.
- `available`  in  1  console idle and ready.
- `please_wait`  out  1  high while FIFO is non-empty or FSM is not IDLE.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `ack_timeout_err`  out  1  sticky; set when WAIT_BUSY times out.

## Operation

- **Reset (`resetn` low, any time, asynchronous):**
  - FIFO flushed; count = 0.
  - FSM = IDLE; all pulses = 0.
  - `symbol_to_insert` = 0, `cursor_dir` = 0, `ack_timeout_err` = 0.
  - `last_grant` = interpreter, so the keypad wins first.
  - An in-flight command is abandoned. It is not replayed.
- **Arbitration:**
  - Ready is computed from registered state only: `full` = (count == FIFO_DEPTH).
  - If full: `kb_ready` = `it_ready` = 0.
  - If not full and one valid: that requester's ready = 1.
  - If not full and both valid: ready goes to the requester not in `last_grant`; the other sees ready = 0.
  - At most one push per cycle. `last_grant` updates on every push.
  - Ready may depend combinationally on valid. A requester must hold valid, op and symbol stable until accepted.
- **FIFO:**
  - Entry = {op, symbol}. Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - A push into a full FIFO cannot occur, because ready is low.
- **Issue FSM:**
  - IDLE: if count > 0 and `available` = 1, pop the head, register the outputs, and go to ISSUE.
    - insert: `insert` = 1, `symbol_to_insert` = symbol.
    - delete: `delete` = 1.
    - move: `move_cursor` = 1, `cursor_dir` = op[0].
  - ISSUE: the pulse is high for exactly this cycle. Go to WAIT_BUSY and clear the timer.
  - WAIT_BUSY:
    - If `available` = 0, go to WAIT_DONE.
    - Else if the timer reaches ACK_TIMEOUT−1, set `ack_timeout_err` and go to IDLE; the command is treated as complete.
    - Otherwise increment the timer.
  - WAIT_DONE: when `available` = 1, go to IDLE.
- Exactly one of `insert`/`delete`/`move_cursor` is high in any cycle, and only in ISSUE.

## Timing

- **Accept:** on edge E0 where valid & ready = 1. Count reflects the push after E0.
- **Issue latency:** FSM in IDLE, FIFO empty, `available` = 1.
  - Accept at E0; pop at E1.
  - Pulse is high from E1 to E2, so first pulse is 1 cycle after accept.
  - Pulse is low from E2.
- **Minimum command period:** 4 cycles when the console drops `available` for one cycle (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE).
- **Timeout path:** pulse, then ACK_TIMEOUT cycles in WAIT_BUSY, then IDLE.
- **Console not ready:** a queued command waits in IDLE while `available` = 0 at the head. No pulse is issued and `please_wait` stays high.
- **Outputs:** `please_wait` and `fifo_count` are registered/derived from registered state only. No combinational path from `available` to any output.

## Test plan

- **Single insert:** reset, `available` = 1. Keypad insert symbol 4'h9 accepted at E0.
  - `insert` high E1–E2 with `symbol_to_insert` = 9.
  - Console drops `available` for 3 cycles; FSM returns to IDLE and `please_wait` falls.
- **Round-robin:** both requesters held valid continuously (keypad move right, interpreter insert 4'h3).
  - Accept order is keypad, interpreter, keypad, interpreter.
  - Issued pulses alternate `move_cursor` (`cursor_dir` = 1) and `insert`.
- **Full FIFO:** `available` held 0 and 5 keypad requests presented.
  - 4 accepted, `fifo_count` = 4, both readies low.
  - No pulse issued until `available` = 1.
  - Commands then drain in FIFO order.
- **Timeout:** console never drops `available`.
  - After the delete pulse, FSM is back in IDLE exactly 8 cycles later.
  - `ack_timeout_err` = 1 and stays 1 until reset.
- **Reset mid-operation:** assert `resetn` low during WAIT_DONE with 2 entries queued.
  - All outputs return to reset values immediately.
  - After release, no pulse is issued and `fifo_count` = 0.

Source files
------------

// File: rtl/console_cmd_scheduler_if.sv
// console_cmd_scheduler_if
// Groups the two requester handshakes and the console command port of the
// command scheduler.
//   kb_* / it_*       : keypad and interpreter requesters (valid/ready, op, symbol)
//   symbol_to_insert  : symbol of the last issued insert
//   insert/delete/move_cursor : one-cycle command pulses to the console
//   cursor_dir        : 1 = right, 0 = left
//   available         : console idle and ready
//   please_wait       : scheduler busy (queue non-empty or command in flight)
//   fifo_count        : current queue occupancy
//   ack_timeout_err   : sticky console acknowledge timeout flag
// Modports: slave = scheduler side, master = requester/console side.
interface console_cmd_scheduler_if #(
  parameter int unsigned SYM_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic             kb_valid;
  logic [1:0]       kb_op;
  logic [SYM_W-1:0] kb_symbol;
  logic             kb_ready;
  logic             it_valid;
  logic [1:0]       it_op;
  logic [SYM_W-1:0] it_symbol;
  logic             it_ready;
  logic [SYM_W-1:0] symbol_to_insert;
  logic             insert;
  logic             delete;
  logic             move_cursor;
  logic             cursor_dir;
  logic             available;
  logic             please_wait;
  logic [CW-1:0]    fifo_count;
  logic             ack_timeout_err;

  modport slave (
    input  kb_valid, kb_op, kb_symbol, it_valid, it_op, it_symbol, available,
    output kb_ready, it_ready, symbol_to_insert, insert, delete, move_cursor,
           cursor_dir, please_wait, fifo_count, ack_timeout_err
  );

  modport master (
    output kb_valid, kb_op, kb_symbol, it_valid, it_op, it_symbol, available,
    input  kb_ready, it_ready, symbol_to_insert, insert, delete, move_cursor,
           cursor_dir, please_wait, fifo_count, ack_timeout_err
  );
endinterface

// File: rtl/console_cmd_scheduler.sv
// console_cmd_scheduler
// Round-robin arbitrates keypad and interpreter edit requests into a small
// FIFO and issues them one at a time to the console as single-cycle
// insert/delete/move_cursor pulses, waiting for the console's `available`
// handshake to drop and recover between commands.
// Ports:
//   working_clock : sole clock, rising edge
//   resetn        : asynchronous active-low reset
//   bus           : console_cmd_scheduler_if.slave (requesters + console port)
module console_cmd_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYM_W       = 4,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input logic                    working_clock,
  input logic                    resetn,
  console_cmd_scheduler_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT) + 1;
  localparam int unsigned EW = SYM_W + 2;

  localparam logic [CW-1:0] CountFull = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TimerLast = TW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StIssue    = 2'd1;
  localparam logic [1:0] StWaitBusy = 2'd2;
  localparam logic [1:0] StWaitDone = 2'd3;

  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [1:0]       r_state;
  logic [TW-1:0]    r_timer;
  logic             r_last_grant;  // 1 = interpreter won the last push
  logic             r_insert, r_delete, r_move, r_dir, r_err;
  logic [SYM_W-1:0] r_sym;

  logic             w_full, w_kb_grant, w_it_grant, w_push, w_pop;
  logic [EW-1:0]    w_push_data, w_head;
  logic [1:0]       w_head_op;
  logic [1:0]       w_state_d;
  logic [TW-1:0]    w_timer_d;
  logic             w_err_d;

  // Ready depends on registered occupancy and last grant, plus requester valids.
  assign w_full      = (r_count == CountFull);
  assign w_kb_grant  = !w_full && bus.kb_valid && (!bus.it_valid || r_last_grant);
  assign w_it_grant  = !w_full && bus.it_valid && (!bus.kb_valid || !r_last_grant);
  assign w_push      = w_kb_grant || w_it_grant;
  assign w_push_data = w_kb_grant ? {bus.kb_op, bus.kb_symbol} : {bus.it_op, bus.it_symbol};
  assign w_pop       = (r_state == StIdle) && (r_count != '0) && bus.available;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_op   = w_head[EW-1:SYM_W];

  always_comb begin
    w_state_d = r_state;
    w_timer_d = r_timer;
    w_err_d   = r_err;
    case (r_state)
      StIdle: if (w_pop) w_state_d = StIssue;
      StIssue: begin
        w_state_d = StWaitBusy;
        w_timer_d = '0;
      end
      StWaitBusy: begin
        if (!bus.available) begin
          w_state_d = StWaitDone;
        end else if (r_timer == TimerLast) begin
          // Console never acknowledged: flag it and treat the command as done.
          w_err_d   = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_timer_d = r_timer + 1'b1;
        end
      end
      StWaitDone: if (bus.available) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge working_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge working_clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_state      <= StIdle;
      r_timer      <= '0;
      r_last_grant <= 1'b1;
      r_insert     <= 1'b0;
      r_delete     <= 1'b0;
      r_move       <= 1'b0;
      r_dir        <= 1'b0;
      r_err        <= 1'b0;
      r_sym        <= '0;
    end else begin
      r_state <= w_state_d;
      r_timer <= w_timer_d;
      r_err   <= w_err_d;
      if (w_push) begin
        r_wr_ptr     <= r_wr_ptr + 1'b1;
        r_last_grant <= w_it_grant;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Pulses are only set on the pop edge, so they live for the ISSUE cycle.
      r_insert <= w_pop && (w_head_op == 2'b00);
      r_delete <= w_pop && (w_head_op == 2'b01);
      r_move   <= w_pop && w_head_op[1];
      if (w_pop && (w_head_op == 2'b00)) r_sym <= w_head[SYM_W-1:0];
      if (w_pop && w_head_op[1]) r_dir <= w_head_op[0];
    end
  end

  assign bus.kb_ready         = w_kb_grant;
  assign bus.it_ready         = w_it_grant;
  assign bus.symbol_to_insert = r_sym;
  assign bus.insert           = r_insert;
  assign bus.delete           = r_delete;
  assign bus.move_cursor      = r_move;
  assign bus.cursor_dir       = r_dir;
  assign bus.please_wait      = (r_count != '0) || (r_state != StIdle);
  assign bus.fifo_count       = r_count;
  assign bus.ack_timeout_err  = r_err;
endmodule

// File: tb/tb_console_cmd_scheduler.sv
// Testbench for console_cmd_scheduler: scoreboard of expected commands,
// popped and compared whenever the scheduler emits a command pulse.
module tb_console_cmd_scheduler;
  logic working_clock = 1'b0;
  logic resetn;
  logic auto_mode, auto_avail, man_avail, saw_pulse;
  int   busy_cnt;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [5:0] exp_q[$];

  always #5 working_clock = ~working_clock;

  console_cmd_scheduler_if #(.SYM_W(4), .FIFO_DEPTH(4)) bus ();

  assign bus.available = auto_mode ? auto_avail : man_avail;

  console_cmd_scheduler #(.FIFO_DEPTH(4), .SYM_W(4), .ACK_TIMEOUT(8)) dut (
    .working_clock(working_clock),
    .resetn       (resetn),
    .bus          (bus.slave)
  );

  // One clock; samples 1 ns after the edge, checks pulses against the
  // scoreboard and runs the console model (drops available for two cycles).
  task automatic step();
    logic [1:0] got_op;
    logic [5:0] e;
    int         npulse;
    @(posedge working_clock);
    #1;
    npulse = int'(bus.insert) + int'(bus.delete) + int'(bus.move_cursor);
    if (npulse != 0) begin
      saw_pulse = 1'b1;
      n_checks++;
      if (npulse != 1) begin
        n_fail++;
        $display("FAIL pulse_onehot: got %0d pulses, required 1", npulse);
      end
      got_op = bus.insert ? 2'b00 : (bus.delete ? 2'b01 : {1'b1, bus.cursor_dir});
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got op %b, required no pulse", got_op);
      end else begin
        e = exp_q.pop_front();
        if (got_op !== e[5:4]) begin
          n_fail++;
          $display("FAIL issue_order: got op %b, required op %b", got_op, e[5:4]);
        end
        if (e[5:4] == 2'b00) begin
          n_checks++;
          if (bus.symbol_to_insert !== e[3:0]) begin
            n_fail++;
            $display("FAIL issue_symbol: got %h, required %h", bus.symbol_to_insert, e[3:0]);
          end
        end
      end
      if (auto_mode) begin
        auto_avail = 1'b0;
        busy_cnt   = 2;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) auto_avail = 1'b1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.kb_valid = 1'b0; bus.kb_op = 2'b00; bus.kb_symbol = 4'h0;
    bus.it_valid = 1'b0; bus.it_op = 2'b00; bus.it_symbol = 4'h0;
    auto_mode = 1'b0; auto_avail = 1'b1; man_avail = 1'b1; busy_cnt = 0;
    exp_q.delete();
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic drain(output logic ok);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) step();
    ok = (exp_q.size() == 0);
    repeat (4) step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.fifo_count !== 3'd0 || bus.please_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got count %0d wait %b, required 0 0", bus.fifo_count,
               bus.please_wait);
    end
    n_checks++;
    if ({bus.insert, bus.delete, bus.move_cursor, bus.cursor_dir, bus.ack_timeout_err} !== 5'b0
        || bus.symbol_to_insert !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b sym %h, required 00000 sym 0",
               {bus.insert, bus.delete, bus.move_cursor, bus.cursor_dir, bus.ack_timeout_err},
               bus.symbol_to_insert);
    end
    bus.kb_valid = 1'b1;
    bus.it_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.kb_ready !== 1'b1 || bus.it_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_grant: got kb %b it %b, required kb 1 it 0", bus.kb_ready,
               bus.it_ready);
    end
    bus.kb_valid = 1'b0;
    bus.it_valid = 1'b0;
  endtask

  task automatic test_single_insert();
    do_reset();
    bus.kb_valid = 1'b1; bus.kb_op = 2'b00; bus.kb_symbol = 4'h9;
    exp_q.push_back({2'b00, 4'h9});
    #1;
    n_checks++;
    if (bus.kb_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: got %b, required 1", bus.kb_ready);
    end
    step();  // E0
    bus.kb_valid = 1'b0;
    n_checks++;
    if (bus.fifo_count !== 3'd1 || bus.insert !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: got count %0d insert %b, required 1 0", bus.fifo_count,
               bus.insert);
    end
    step();  // E1
    n_checks++;
    if (bus.insert !== 1'b1 || bus.symbol_to_insert !== 4'h9) begin
      n_fail++;
      $display("FAIL single_pulse: got insert %b sym %h, required 1 9", bus.insert,
               bus.symbol_to_insert);
    end
    step();  // E2
    n_checks++;
    if (bus.insert !== 1'b0 || bus.symbol_to_insert !== 4'h9) begin
      n_fail++;
      $display("FAIL single_pulse_end: got insert %b sym %h, required 0 9", bus.insert,
               bus.symbol_to_insert);
    end
    man_avail = 1'b0;
    repeat (3) step();
    n_checks++;
    if (bus.please_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_wait: got %b, required 1", bus.please_wait);
    end
    man_avail = 1'b1;
    step();
    n_checks++;
    if (bus.please_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got please_wait %b, required 0", bus.please_wait);
    end
  endtask

  task automatic test_round_robin();
    logic expect_kb;
    logic ok;
    int   nacc;
    do_reset();
    auto_mode = 1'b1;
    bus.kb_valid = 1'b1; bus.kb_op = 2'b11; bus.kb_symbol = 4'h0;
    bus.it_valid = 1'b1; bus.it_op = 2'b00; bus.it_symbol = 4'h3;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({2'b11, 4'h0});
      exp_q.push_back({2'b00, 4'h3});
    end
    expect_kb = 1'b1;
    nacc = 0;
    for (int i = 0; i < 12 && nacc < 4; i++) begin
      #1;
      n_checks++;
      if (bus.kb_ready !== expect_kb || bus.it_ready !== !expect_kb) begin
        n_fail++;
        $display("FAIL rr_grant: got kb %b it %b, required kb %b it %b", bus.kb_ready,
                 bus.it_ready, expect_kb, !expect_kb);
      end
      if (bus.kb_ready || bus.it_ready) begin
        nacc++;
        expect_kb = !expect_kb;
      end
      step();
    end
    bus.kb_valid = 1'b0;
    bus.it_valid = 1'b0;
    drain(ok);
    n_checks++;
    if (!ok || bus.please_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drain: got %0d left wait %b, required 0 0", exp_q.size(),
               bus.please_wait);
    end
  endtask

  task automatic test_full_fifo();
    logic ok;
    do_reset();
    man_avail = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.kb_valid = 1'b1; bus.kb_op = 2'(i); bus.kb_symbol = 4'(i + 1);
      exp_q.push_back({2'(i), 4'(i + 1)});
      #1;
      n_checks++;
      if (bus.kb_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL full_accept_%0d: got ready %b, required 1", i, bus.kb_ready);
      end
      step();
    end
    bus.kb_op = 2'b00; bus.kb_symbol = 4'hA;
    bus.it_valid = 1'b1; bus.it_op = 2'b01;
    #1;
    n_checks++;
    if (bus.fifo_count !== 3'd4 || bus.kb_ready !== 1'b0 || bus.it_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got count %0d kb %b it %b, required 4 0 0", bus.fifo_count,
               bus.kb_ready, bus.it_ready);
    end
    saw_pulse = 1'b0;
    repeat (5) step();
    n_checks++;
    if (saw_pulse !== 1'b0 || bus.fifo_count !== 3'd4 || bus.please_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL full_hold: got pulse %b count %0d wait %b, required 0 4 1", saw_pulse,
               bus.fifo_count, bus.please_wait);
    end
    bus.kb_valid = 1'b0;
    bus.it_valid = 1'b0;
    auto_mode = 1'b1;
    drain(ok);
    n_checks++;
    if (!ok || bus.fifo_count !== 3'd0 || bus.please_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain: got %0d left count %0d, required 0 0", exp_q.size(),
               bus.fifo_count);
    end
  endtask

  task automatic test_timeout();
    logic ok;
    do_reset();
    bus.kb_valid = 1'b1; bus.kb_op = 2'b01; bus.kb_symbol = 4'h0;
    exp_q.push_back({2'b01, 4'h0});
    step();  // E0
    bus.kb_valid = 1'b0;
    saw_pulse = 1'b0;
    step();  // E1
    n_checks++;
    if (saw_pulse !== 1'b1 || bus.delete !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_pulse: got delete %b, required 1", bus.delete);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (bus.please_wait !== 1'b1 || bus.ack_timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait_%0d: got wait %b err %b, required 1 0", k,
                 bus.please_wait, bus.ack_timeout_err);
      end
    end
    step();
    n_checks++;
    if (bus.please_wait !== 1'b0 || bus.ack_timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_expire: got wait %b err %b, required 0 1", bus.please_wait,
               bus.ack_timeout_err);
    end
    // A normal command afterwards must leave the error flag set.
    auto_mode = 1'b1;
    bus.kb_valid = 1'b1; bus.kb_op = 2'b11; bus.kb_symbol = 4'h0;
    exp_q.push_back({2'b11, 4'h0});
    step();
    bus.kb_valid = 1'b0;
    drain(ok);
    n_checks++;
    if (!ok || bus.ack_timeout_err !== 1'b1 || bus.cursor_dir !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got err %b dir %b, required 1 1", bus.ack_timeout_err,
               bus.cursor_dir);
    end
  endtask

  task automatic test_reset_mid_op();
    auto_mode = 1'b0;
    man_avail = 1'b1;
    bus.kb_valid = 1'b1; bus.kb_op = 2'b00; bus.kb_symbol = 4'h5;
    exp_q.push_back({2'b00, 4'h5});
    step();  // E0: accept A
    bus.kb_op = 2'b01; bus.kb_symbol = 4'h0;
    step();  // E1: issue A, accept B
    bus.kb_op = 2'b10;
    man_avail = 1'b0;
    step();  // E2: accept C
    bus.kb_valid = 1'b0;
    step();  // E3: WAIT_DONE
    n_checks++;
    if (bus.fifo_count !== 3'd2 || bus.please_wait !== 1'b1 || bus.symbol_to_insert !== 4'h5)
    begin
      n_fail++;
      $display("FAIL midrst_pre: got count %0d wait %b sym %h, required 2 1 5", bus.fifo_count,
               bus.please_wait, bus.symbol_to_insert);
    end
    #1;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (bus.fifo_count !== 3'd0 || bus.please_wait !== 1'b0 || bus.symbol_to_insert !== 4'h0
        || bus.cursor_dir !== 1'b0 || bus.ack_timeout_err !== 1'b0
        || {bus.insert, bus.delete, bus.move_cursor} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_async: got count %0d wait %b sym %h dir %b err %b, required 0s",
               bus.fifo_count, bus.please_wait, bus.symbol_to_insert, bus.cursor_dir,
               bus.ack_timeout_err);
    end
    man_avail = 1'b1;
    step();
    step();
    resetn = 1'b1;
    exp_q.delete();
    saw_pulse = 1'b0;
    repeat (10) step();
    n_checks++;
    if (saw_pulse !== 1'b0 || bus.fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_after: got pulse %b count %0d, required 0 0", saw_pulse,
               bus.fifo_count);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    saw_pulse = 1'b0;
    test_reset();
    test_single_insert();
    test_round_robin();
    test_full_fifo();
    test_timeout();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
